// File: rtl/cmd_pkg.sv
// Shared types and default constants for the UART command parser.
package cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARGS,
    SEND,
    WAIT_BUSY,
    WAIT_IDLE
  } state_t;

  localparam logic [7:0] NAK_BYTE_DEF = 8'h15;
  localparam logic [7:0] OP_FIRST_DEF = 8'h41;
  localparam logic [7:0] OP_LAST_DEF  = 8'h43;

endpackage

// File: rtl/cmd_tx_seq.sv
// Transmit sequencer: sends a loaded byte vector MSB-first, one byte per
// transmitter handshake (send, wait for busy, wait for idle).
module cmd_tx_seq
  import cmd_pkg::*;
#(
  parameter int unsigned ARG_BYTES = 1,
  localparam int unsigned CW = $clog2(ARG_BYTES + 2),
  localparam int unsigned VW = 8 * (ARG_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] count,
  input  logic [VW-1:0] bytes,
  input  logic          tx_active,
  output logic          tx_send,
  output logic [7:0]    tx_data,
  output logic          done
);

  state_t        state;
  logic [VW-1:0] pend;
  logic [CW-1:0] remaining;

  // Combinational so the parser can return to IDLE on the same edge we do.
  assign done = (state == WAIT_IDLE) && !tx_active && (remaining == '0);

  // Handshake FSM; tx_send is only raised from SEND, so each byte goes out once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend      <= '0;
      remaining <= '0;
      tx_send   <= 1'b0;
      tx_data   <= '0;
    end else begin
      tx_send <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            pend      <= bytes;
            remaining <= count;
            state     <= SEND;
          end
        end
        SEND: begin
          if (!tx_active) begin
            tx_data   <= pend[VW-1 -: 8];
            pend      <= pend << 8;
            remaining <= remaining - CW'(1);
            tx_send   <= 1'b1;
            state     <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_active) state <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if (!tx_active) state <= (remaining != '0) ? SEND : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cmd_parser.sv
// UART command parser: opcode byte plus ARG_BYTES argument bytes, with
// inter-byte timeout, NAK on errors and optional echo of each command.
module cmd_parser
  import cmd_pkg::*;
#(
  parameter int unsigned ARG_BYTES   = 1,
  parameter logic [7:0]  OP_FIRST    = OP_FIRST_DEF,
  parameter logic [7:0]  OP_LAST     = OP_LAST_DEF,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter bit          ECHO        = 1'b1,
  parameter logic [7:0]  NAK_BYTE    = NAK_BYTE_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_data_ready,
  input  logic [7:0]               rx_data,
  input  logic                     tx_active,
  output logic                     cmd_ready,
  output logic [8+8*ARG_BYTES-1:0] cmd,
  output logic                     cmd_err,
  output logic                     tx_send,
  output logic [7:0]               tx_data
);

  localparam int unsigned AW    = $clog2(ARG_BYTES + 1);
  localparam int unsigned TW    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned CW    = $clog2(ARG_BYTES + 2);
  localparam int unsigned AGW   = 8 * ARG_BYTES;
  localparam int unsigned CMD_W = 8 + AGW;

  localparam logic [AW-1:0] LAST_IDX   = AW'(ARG_BYTES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [CW-1:0] ECHO_CNT   = CW'(ARG_BYTES + 1);
  localparam logic [CW-1:0] NAK_CNT    = CW'(1);

  state_t           state;
  logic [7:0]       opcode;
  logic [AGW-1:0]   args;
  logic [AGW-1:0]   args_next;
  logic [AGW+7:0]   args_ext;
  logic [AW-1:0]    arg_idx;
  logic [TW-1:0]    timer;
  logic             op_ok;
  logic             last_arg;
  logic             expired;
  logic             load;
  logic [CW-1:0]    load_count;
  logic [CMD_W-1:0] load_bytes;
  logic             tx_done;

  // Decode the incoming byte and build the load request for the tx sequencer
  // in the same cycle, so the first tx_send lands two cycles after the byte.
  always_comb begin
    op_ok      = (rx_data >= OP_FIRST) && (rx_data <= OP_LAST);
    args_ext   = {args, rx_data};
    args_next  = args_ext[AGW-1:0];
    last_arg   = (arg_idx == LAST_IDX);
    expired    = (TIMEOUT_CYC != 0) && (timer == TIMER_LAST);
    load       = 1'b0;
    load_count = '0;
    load_bytes = '0;
    case (state)
      IDLE: begin
        if (rx_data_ready && !op_ok) begin
          load       = 1'b1;
          load_count = NAK_CNT;
          load_bytes = {NAK_BYTE, {AGW{1'b0}}};
        end
      end
      ARGS: begin
        if (rx_data_ready) begin
          if (last_arg && ECHO) begin
            load       = 1'b1;
            load_count = ECHO_CNT;
            load_bytes = {opcode, args_next};
          end
        end else if (expired) begin
          load       = 1'b1;
          load_count = NAK_CNT;
          load_bytes = {NAK_BYTE, {AGW{1'b0}}};
        end
      end
      default: ;
    endcase
  end

  // Parser FSM and inter-byte timer; SEND covers the whole tx sequence
  // and ends when the sequencer reports done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      opcode    <= '0;
      args      <= '0;
      arg_idx   <= '0;
      timer     <= '0;
      cmd       <= '0;
      cmd_ready <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      cmd_ready <= 1'b0;
      cmd_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_data_ready) begin
            if (op_ok) begin
              opcode  <= rx_data;
              arg_idx <= '0;
              timer   <= '0;
              state   <= ARGS;
            end else begin
              cmd_err <= 1'b1;
              state   <= SEND;
            end
          end
        end
        ARGS: begin
          if (rx_data_ready) begin
            args    <= args_next;
            arg_idx <= arg_idx + AW'(1);
            timer   <= '0;
            if (last_arg) begin
              cmd       <= {opcode, args_next};
              cmd_ready <= 1'b1;
              arg_idx   <= '0;
              state     <= ECHO ? SEND : IDLE;
            end
          end else if (expired) begin
            cmd_err <= 1'b1;
            arg_idx <= '0;
            timer   <= '0;
            state   <= SEND;
          end else if (timer != '1) begin
            timer <= timer + TW'(1);
          end
        end
        SEND: begin
          if (tx_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  cmd_tx_seq #(
    .ARG_BYTES(ARG_BYTES)
  ) u_tx_seq (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .count     (load_count),
    .bytes     (load_bytes),
    .tx_active (tx_active),
    .tx_send   (tx_send),
    .tx_data   (tx_data),
    .done      (tx_done)
  );

endmodule

// File: tb/tb_cmd_parser.sv
// Testbench for cmd_parser with ARG_BYTES=2, ECHO=1, TIMEOUT_CYC=100.
module tb_cmd_parser;

  localparam int unsigned AB = 2;
  localparam int unsigned TO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_data_ready;
  logic [7:0]  rx_data;
  logic        tx_active;
  logic        cmd_ready;
  logic [23:0] cmd;
  logic        cmd_err;
  logic        tx_send;
  logic [7:0]  tx_data;

  logic tx_busy;
  logic tx_hold;
  assign tx_active = tx_busy | tx_hold;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int          busy_len = 2;
  int          n_ready = 0;
  int          n_err = 0;
  int          n_viol = 0;
  int unsigned ready_cyc = 0;
  int unsigned err_cyc = 0;
  logic [7:0]  tx_q[$];
  int unsigned send_cyc[$];
  logic        act_at_edge = 1'b0;
  logic [23:0] model_cmd = '0;
  int          r0, e0, v0;

  cmd_parser #(
    .ARG_BYTES   (AB),
    .OP_FIRST    (8'h41),
    .OP_LAST     (8'h43),
    .TIMEOUT_CYC (TO),
    .ECHO        (1'b1),
    .NAK_BYTE    (8'h15)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data_ready (rx_data_ready),
    .rx_data       (rx_data),
    .tx_active     (tx_active),
    .cmd_ready     (cmd_ready),
    .cmd           (cmd),
    .cmd_err       (cmd_err),
    .tx_send       (tx_send),
    .tx_data       (tx_data)
  );

  always #5 clk = ~clk;

  // Edge counter and tx_active as seen by the DUT at each rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    act_at_edge = tx_active;
  end

  // Output monitor.
  initial forever begin
    @(negedge clk);
    if (cmd_ready) begin n_ready++; ready_cyc = cyc; end
    if (cmd_err) begin n_err++; err_cyc = cyc; end
    if (tx_send) begin
      tx_q.push_back(tx_data);
      send_cyc.push_back(cyc);
      if (act_at_edge) n_viol++;
    end
  end

  // Transmitter model: goes busy for busy_len cycles after each tx_send.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_send) begin
        tx_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  function automatic bit op_valid(input logic [7:0] b);
    return (b >= 8'h41) && (b <= 8'h43);
  endfunction

  function automatic logic [31:0] pack_q(input logic [7:0] q[$]);
    logic [31:0] p = '0;
    foreach (q[i]) p = {p[23:0], q[i]};
    return p;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int unsigned edge_no);
    rx_data_ready = 1'b1;
    rx_data = b;
    step();
    rx_data_ready = 1'b0;
    rx_data = 8'($urandom);
    edge_no = cyc;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (tx_q.size() < n && k < budget) begin step(); k++; end
  endtask

  task automatic settle();
    int quiet = 0;
    int k = 0;
    while (quiet < 4 && k < 500) begin
      step();
      k++;
      quiet = tx_active ? 0 : quiet + 1;
    end
  endtask

  task automatic begin_scn();
    tx_q.delete();
    send_cyc.delete();
    r0 = n_ready;
    e0 = n_err;
    v0 = n_viol;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_data_ready = 1'b0;
    rx_data = '0;
    tx_hold = 1'b0;
    repeat (3) step();
    total++;
    if ({cmd_ready, cmd_err, tx_send} !== 3'b000) begin
      bad++;
      $display("FAIL reset_strobes: got %b want 000", {cmd_ready, cmd_err, tx_send});
    end
    total++;
    if ({cmd, tx_data} !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: got cmd=%h tx_data=%h want 0", cmd, tx_data);
    end
    rst = 1'b0;
    step();
    model_cmd = '0;
  endtask

  task automatic test_echo();
    int unsigned e, el;
    begin_scn();
    busy_len = 3;
    send_byte(8'h42, e);
    send_byte(8'h12, e);
    send_byte(8'h34, el);
    wait_tx(3, 300);
    settle();
    model_cmd = 24'h421234;
    total++;
    if (n_ready - r0 !== 1 || n_err - e0 !== 0) begin
      bad++;
      $display("FAIL echo_counts: got ready=%0d err=%0d want 1 0", n_ready - r0, n_err - e0);
    end
    total++;
    if (cmd !== model_cmd) begin
      bad++;
      $display("FAIL echo_cmd: got %h want %h", cmd, model_cmd);
    end
    total++;
    if (ready_cyc !== el) begin
      bad++;
      $display("FAIL echo_ready_latency: got edge %0d want %0d", ready_cyc, el);
    end
    total++;
    if (tx_q.size() !== 3 || pack_q(tx_q) !== 32'h00421234) begin
      bad++;
      $display("FAIL echo_bytes: got n=%0d %h want n=3 00421234", tx_q.size(), pack_q(tx_q));
    end
    total++;
    if (send_cyc.size() == 0 || send_cyc[0] !== el + 1) begin
      bad++;
      $display("FAIL echo_first_send: got %0d entries want send at edge %0d", send_cyc.size(), el + 1);
    end
    total++;
    if (n_viol - v0 !== 0) begin
      bad++;
      $display("FAIL echo_handshake: got %0d sends while busy want 0", n_viol - v0);
    end
    busy_len = 2;
  endtask

  task automatic test_bad_opcode();
    int unsigned e;
    begin_scn();
    send_byte(8'h5A, e);
    wait_tx(1, 100);
    settle();
    total++;
    if (n_err - e0 !== 1 || err_cyc !== e || n_ready - r0 !== 0) begin
      bad++;
      $display("FAIL nak_err: got err=%0d at %0d ready=%0d want 1 at %0d 0", n_err - e0, err_cyc, n_ready - r0, e);
    end
    total++;
    if (tx_q.size() !== 1 || pack_q(tx_q) !== 32'h15 || send_cyc[0] !== e + 1) begin
      bad++;
      $display("FAIL nak_send: got n=%0d %h want n=1 15 at edge %0d", tx_q.size(), pack_q(tx_q), e + 1);
    end
    total++;
    if (cmd !== model_cmd) begin
      bad++;
      $display("FAIL nak_cmd_hold: got %h want %h", cmd, model_cmd);
    end
    begin_scn();
    send_byte(8'h41, e);
    send_byte(8'h01, e);
    send_byte(8'h02, e);
    wait_tx(3, 300);
    settle();
    model_cmd = 24'h410102;
    total++;
    if (cmd !== model_cmd || n_ready - r0 !== 1 || pack_q(tx_q) !== 32'h00410102) begin
      bad++;
      $display("FAIL after_nak_cmd: got %h tx=%h want %h", cmd, pack_q(tx_q), model_cmd);
    end
  endtask

  task automatic test_timeout();
    int unsigned e;
    int k = 0;
    begin_scn();
    send_byte(8'h43, e);
    send_byte(8'h55, e);
    while (n_err == e0 && k < 300) begin step(); k++; end
    wait_tx(1, 100);
    settle();
    total++;
    if (n_err - e0 !== 1 || err_cyc - e !== TO) begin
      bad++;
      $display("FAIL timeout_err: got err=%0d after %0d cycles want 1 after %0d", n_err - e0, err_cyc - e, TO);
    end
    total++;
    if (tx_q.size() !== 1 || pack_q(tx_q) !== 32'h15 || n_ready - r0 !== 0) begin
      bad++;
      $display("FAIL timeout_nak: got n=%0d %h ready=%0d want n=1 15 0", tx_q.size(), pack_q(tx_q), n_ready - r0);
    end
    total++;
    if (cmd !== model_cmd) begin
      bad++;
      $display("FAIL timeout_cmd_hold: got %h want %h", cmd, model_cmd);
    end
  endtask

  task automatic test_expiry_byte();
    int unsigned e, e2;
    begin_scn();
    send_byte(8'h43, e);
    send_byte(8'h55, e);
    repeat (TO - 1) step();
    send_byte(8'h66, e2);
    wait_tx(3, 300);
    settle();
    model_cmd = 24'h435566;
    total++;
    if (n_err - e0 !== 0 || n_ready - r0 !== 1) begin
      bad++;
      $display("FAIL expiry_counts: got err=%0d ready=%0d want 0 1 (byte at +%0d)", n_err - e0, n_ready - r0, e2 - e);
    end
    total++;
    if (cmd !== model_cmd || pack_q(tx_q) !== 32'h00435566) begin
      bad++;
      $display("FAIL expiry_cmd: got %h tx=%h want %h", cmd, pack_q(tx_q), model_cmd);
    end
  endtask

  task automatic test_busy_hold();
    int unsigned e;
    int held_sends;
    begin_scn();
    busy_len = 10;
    tx_hold = 1'b1;
    send_byte(8'h41, e);
    send_byte(8'h11, e);
    send_byte(8'h22, e);
    send_byte(8'h42, e);
    send_byte(8'h5A, e);
    send_byte(8'h00, e);
    repeat (44) step();
    held_sends = tx_q.size();
    tx_hold = 1'b0;
    wait_tx(1, 100);
    send_byte(8'h43, e);
    wait_tx(3, 300);
    settle();
    repeat (20) step();
    model_cmd = 24'h411122;
    total++;
    if (held_sends !== 0) begin
      bad++;
      $display("FAIL hold_no_send: got %0d sends during hold want 0", held_sends);
    end
    total++;
    if (tx_q.size() !== 3 || pack_q(tx_q) !== 32'h00411122 || n_viol - v0 !== 0) begin
      bad++;
      $display("FAIL hold_bytes: got n=%0d %h viol=%0d want n=3 00411122 0", tx_q.size(), pack_q(tx_q), n_viol - v0);
    end
    total++;
    if (n_ready - r0 !== 1 || n_err - e0 !== 0 || cmd !== model_cmd) begin
      bad++;
      $display("FAIL hold_ignore_rx: got ready=%0d err=%0d cmd=%h want 1 0 %h", n_ready - r0, n_err - e0, cmd, model_cmd);
    end
    busy_len = 2;
  endtask

  task automatic test_reset_mid();
    int unsigned e;
    begin_scn();
    busy_len = 20;
    send_byte(8'h42, e);
    send_byte(8'h01, e);
    send_byte(8'h02, e);
    wait_tx(1, 100);
    rst = 1'b1;
    step();
    total++;
    if ({cmd_ready, cmd_err, tx_send} !== 3'b000 || {cmd, tx_data} !== 32'h0) begin
      bad++;
      $display("FAIL midreset_outputs: got %b cmd=%h tx_data=%h want 000 0 0", {cmd_ready, cmd_err, tx_send}, cmd, tx_data);
    end
    rst = 1'b0;
    model_cmd = '0;
    repeat (60) step();
    total++;
    if (tx_q.size() !== 1) begin
      bad++;
      $display("FAIL midreset_no_resend: got %0d sends want 1", tx_q.size());
    end
    busy_len = 2;
    begin_scn();
    send_byte(8'h41, e);
    send_byte(8'h00, e);
    send_byte(8'h01, e);
    wait_tx(3, 300);
    settle();
    model_cmd = 24'h410001;
    total++;
    if (cmd !== model_cmd || pack_q(tx_q) !== 32'h00410001 || n_ready - r0 !== 1) begin
      bad++;
      $display("FAIL midreset_recover: got %h tx=%h want %h", cmd, pack_q(tx_q), model_cmd);
    end
  endtask

  task automatic test_random();
    int unsigned e;
    logic [7:0] op, a0, a1;
    logic [31:0] exp_tx;
    int exp_n, exp_r, exp_e;
    for (int it = 0; it < 20; it++) begin
      begin_scn();
      busy_len = int'($urandom_range(1, 6));
      op = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(8'h41, 8'h43)) : 8'($urandom_range(0, 255));
      a0 = 8'($urandom);
      a1 = 8'($urandom);
      if (op_valid(op)) begin
        send_byte(op, e);
        repeat ($urandom_range(0, 30)) step();
        send_byte(a0, e);
        repeat ($urandom_range(0, 30)) step();
        send_byte(a1, e);
        model_cmd = {op, a0, a1};
        exp_tx = {8'h00, op, a0, a1};
        exp_n = 3; exp_r = 1; exp_e = 0;
      end else begin
        send_byte(op, e);
        exp_tx = 32'h15;
        exp_n = 1; exp_r = 0; exp_e = 1;
      end
      wait_tx(exp_n, 400);
      settle();
      total++;
      if (cmd !== model_cmd) begin
        bad++;
        $display("FAIL rand_cmd[%0d]: got %h want %h", it, cmd, model_cmd);
      end
      total++;
      if (tx_q.size() !== exp_n || pack_q(tx_q) !== exp_tx) begin
        bad++;
        $display("FAIL rand_tx[%0d]: got n=%0d %h want n=%0d %h", it, tx_q.size(), pack_q(tx_q), exp_n, exp_tx);
      end
      total++;
      if (n_ready - r0 !== exp_r || n_err - e0 !== exp_e || n_viol - v0 !== 0) begin
        bad++;
        $display("FAIL rand_strobes[%0d]: got ready=%0d err=%0d viol=%0d want %0d %0d 0", it, n_ready - r0, n_err - e0, n_viol - v0, exp_r, exp_e);
      end
    end
    busy_len = 2;
  endtask

  initial begin
    test_reset();
    test_echo();
    test_bad_opcode();
    test_timeout();
    test_expiry_byte();
    test_busy_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_parser.md
# cmd_parser

Parametrised UART command parser. It sits between the UART receiver and transmitter, next to the waveform-generator control logic. It accepts an opcode byte from a configurable range followed by ARG_BYTES argument bytes, and presents the assembled command as a one-cycle strobe. It then optionally echoes the command back over UART. Beyond the single-argument handler it adds an inter-byte timeout, NAK replies for bad opcodes and timeouts, and a tx handshake that cannot double-send.

## Interface
- ARG_BYTES, 1: argument bytes per command; legal range 1..8.
- OP_FIRST, 8'h41 ("A"): lowest valid opcode.
- OP_LAST, 8'h43 ("C"): highest valid opcode, inclusive.
- TIMEOUT_CYC, 1000000: max clk cycles between argument bytes; 0 disables the timeout.
- ECHO, 1: 1 = echo opcode and args after each command; 0 = no echo.
- NAK_BYTE, 8'h15: byte sent on an error.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data_ready  in  1  one-cycle strobe: rx_data holds a new byte.
- rx_data  in  8  received byte.
- tx_active  in  1  transmitter busy.
- cmd_ready  out  1  one-cycle strobe: cmd holds a new command.
- cmd  out  8+8*ARG_BYTES  {opcode, arg0, arg1, ...}; arg0 is the first byte received and the most significant argument byte; held until the next command.
- cmd_err  out  1  one-cycle strobe on bad opcode or timeout.
- tx_send  out  1  one-cycle strobe: transmit tx_data.
- tx_data  out  8  byte to transmit.

## Operation
- Reset: state IDLE; cmd, tx_data, counters = 0; cmd_ready, cmd_err, tx_send = 0.
- States: IDLE, ARGS, SEND, WAIT_BUSY, WAIT_IDLE.
- IDLE:
  - Byte in [OP_FIRST, OP_LAST]: latch as opcode, clear arg index and timer, go to ARGS.
  - Any other byte: pulse cmd_err and queue NAK_BYTE for send (always, regardless of ECHO), go to SEND.
- ARGS:
  - Each byte is stored at arg index k, k increments, timer clears.
  - On byte ARG_BYTES-1: load cmd next edge, pulse cmd_ready the same edge. Then go to SEND with the echo queue loaded (opcode first), or to IDLE if ECHO=0.
  - Timer increments each cycle without a byte. On reaching TIMEOUT_CYC-1 with no byte: pulse cmd_err, discard the partial command, cmd unchanged, queue NAK_BYTE, go to SEND.
  - Byte and timeout expiry in the same cycle: the byte wins.
- SEND: when tx_active=0, drive tx_data with the queued byte, pulse tx_send for one cycle, go to WAIT_BUSY.
- WAIT_BUSY: wait for tx_active=1, then go to WAIT_IDLE. No tx_send is issued here, so a byte is never sent twice.
- WAIT_IDLE: wait for tx_active=0. If bytes remain, go to SEND; else go to IDLE.
- rx bytes arriving in SEND, WAIT_BUSY or WAIT_IDLE are dropped silently.
- rst in any state, including mid-transmit: return to the reset values next edge. No further tx_send is issued.
- Widths:
  - Arg index: $clog2(ARG_BYTES+1) bits.
  - Timer: $clog2(TIMEOUT_CYC+1) bits; saturating, so no wrap.
  - Echo byte index: $clog2(ARG_BYTES+2) bits.

## Timing
- Last arg byte strobe at edge N → cmd valid and cmd_ready=1 in cycle N+1.
- With tx_active=0, the first echo tx_send follows in cycle N+2.
- Bad opcode at edge N → cmd_err=1 in cycle N+1; NAK tx_send in cycle N+2 if tx_active=0.
- Timeout: cmd_err asserts TIMEOUT_CYC cycles after the last accepted byte.
- All outputs are registered; no combinational path from input to output.
- Echo of one command takes 1+ARG_BYTES transmitter handshakes.

## Structure
- Package cmd_pkg holds:
  - the state enum;
  - NAK_BYTE default;
  - default OP_FIRST and OP_LAST.
- One sub-module, cmd_tx_seq, owns the SEND/WAIT_BUSY/WAIT_IDLE handshake. Interface: load strobe, byte count, byte vector in; tx_send/tx_data out; done strobe.
- The parser FSM and timer stay in cmd_parser.

## Test plan
- ARG_BYTES=2, ECHO=1, TIMEOUT_CYC=100; send "B",8'h12,8'h34 → one cmd_ready pulse, cmd=24'h421234. Then tx_send ×3 with tx_data 8'h42, 8'h12, 8'h34, each only after tx_active falls.
- Send "Z" → cmd_err pulse, one tx_send with 8'h15, cmd unchanged, then "A",8'h01,8'h02 is parsed normally to cmd=24'h410102.
- Send "C",8'h55, then 100 idle cycles → cmd_err pulse after 100 cycles, NAK sent, no cmd_ready.
- Same as above, but 8'h66 arrives on exactly the expiry cycle → byte accepted, cmd=24'h435566, no cmd_err.
- Hold tx_active=1 for 50 cycles during the echo → exactly one tx_send per byte, none while tx_active=1; extra rx bytes during the echo are ignored.
- Assert rst during WAIT_BUSY → all outputs 0 next cycle; a following "A",8'h00,8'h01 gives cmd=24'h410001.
